hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage RISC-V pipeline (Fetch/Decode/Execute/Memory/Writeback).
- Generates forwarding selects, load-use stalls, branch flushes and data-memory wait stalls.
- After reset, runs a 32-cycle register-file clear sequence through the Writeback write port before releasing the pipeline. This is needed because the register file has no reset.

Parameters:
- NUM_REGS, 32, number of architectural registers cleared during init.
- ADDR_W, 5, register address width; NUM_REGS must equal 2**ADDR_W.
- SKIP_INIT, 0, 1 = go directly from reset to RUN with no clear sequence (simulation speed-up).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-low
- Rs1D, Rs2D  in  ADDR_W  source registers of the instruction in Decode
- Rs1E, Rs2E, RdE  in  ADDR_W  source/destination registers in Execute
- RdM, RdW  in  ADDR_W  destination registers in Memory/Writeback
- RegWriteM, RegWriteW  in  1  register-write enables in Memory/Writeback
- ResultSrcE  in  1  Execute instruction is a load
- PCSrcE  in  1  taken branch resolved in Execute
- dmem_req_M  in  1  Memory stage is accessing data memory
- dmem_ready  in  1  data memory completes the access this cycle
- ForwardAE, ForwardBE  out  2  00 = register file, 10 = forward from Memory ALU result, 01 = forward from ResultW
- StallF, StallD, StallE, StallM  out  1  hold the pipeline register feeding that stage
- FlushD, FlushE, FlushW  out  1  load a bubble (all control bits zero) into that stage
- init_we, init_addr, init_busy  out  1/ADDR_W/1  register-file clear write port and busy flag

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-low. On a clk edge with rst=0: state<=INIT (or RUN if SKIP_INIT=1), init counter<=0.
- Output values while rst=0 (INIT case): Stall*=1, FlushE=1, FlushD=0, FlushW=0, ForwardAE=ForwardBE=00, init_we=0, init_addr=0, init_busy=1.
- INIT state:
  - init_we = rst, init_addr = counter. Write data is zero and is muxed in externally.
  - StallF=StallD=StallE=StallM=1, FlushE=1, init_busy=1.
  - Counter increments every cycle. On counter==NUM_REGS-1, go to RUN; the counter wraps to 0.
  - Exactly NUM_REGS writes occur, addresses 0..NUM_REGS-1 in order.
- RUN state: init_busy=0, init_we=0.
  - Load-use hazard: lwStall = ResultSrcE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D). Effect: StallF=StallD=1, FlushE=1 in the same cycle.
  - Branch: PCSrcE=1 gives FlushD=1 and FlushE=1 in the same cycle. When branch and lwStall coincide, the branch wins: StallF=StallD=0, FlushD=FlushE=1.
  - Memory wait: dmem_req_M=1 with dmem_ready=0 gives StallF/D/E/M=1 and FlushW=1 in the same cycle, then go to MEM_WAIT. dmem_req_M=1 with dmem_ready=1 causes no stall.
- MEM_WAIT state:
  - StallF/D/E/M=1 and FlushW=1 for as long as dmem_ready=0. Branch and load-use flushes are suppressed because the stages are frozen.
  - On dmem_ready=1: the current cycle still holds the stalls, and the next state is RUN.
  - Release happens the cycle after ready is seen, so the Memory result is captured exactly once.
- Forwarding (combinational, all states, forced 00 in INIT):
  - ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Otherwise ForwardAE=01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Otherwise ForwardAE=00. Memory has priority over Writeback.
  - ForwardBE is identical, using Rs2E.
- x0 never triggers a forward or a stall.
- Reset in mid-operation (any state, rst=0) returns to INIT on the next edge. Pending waits are abandoned.
- State encoding INIT=2'b00, RUN=2'b01, MEM_WAIT=2'b10. Unused code 2'b11 goes to INIT.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds outputs stall_cnt[31:0] and flush_cnt[31:0]. Both clear on reset.
- stall_cnt increments once per RUN/MEM_WAIT cycle with StallF=1.
- flush_cnt increments once per cycle with FlushD|FlushE=1 in RUN.
- Both counters wrap silently at 2^32.
- When not defined, the counters and ports are absent and behaviour is otherwise identical.

Decomposition:
- hazard_pkg holds: state encodings (INIT/RUN/MEM_WAIT), forward-select constants (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10), and the default ADDR_W.
- One natural sub-module: forward_unit, purely combinational ForwardAE/ForwardBE logic. It is instantiated once in hazard_ctrl.

Test Plan:
- Reset then release, SKIP_INIT=0 -> init_we high for 32 cycles with init_addr 0..31; init_busy falls on cycle 33; Stall* fall together.
- Execute lw with RdE=5, Decode Rs1D=5 -> StallF=StallD=FlushE=1 for one cycle; same with RdE=0 -> no stall.
- RegWriteM=1, RdM=7, RegWriteW=1, RdW=7, Rs1E=7 -> ForwardAE=10; with RegWriteM=0 -> ForwardAE=01.
- PCSrcE=1 together with a load-use match -> FlushD=FlushE=1, StallF=0.
- dmem_req_M=1, dmem_ready low for 3 cycles -> StallM=FlushW=1 for 4 cycles; released on the 5th.
- rst=0 while in MEM_WAIT -> next cycle state INIT, init_addr=0, init_we=1 after rst returns high.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
// Optional perf counters in hazard_ctrl are enabled by HAZARD_PERF_CNT_EN.
package hazard_pkg;

    localparam int HZ_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_INIT     = 2'b00,
        ST_RUN      = 2'b01,
        ST_MEM_WAIT = 2'b10
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// Operand bypass selection for the Execute stage.
// Memory-stage results take priority over Writeback; x0 never forwards.
module forward_unit
    import hazard_pkg::*;
#(
    parameter int ADDR_W = HZ_ADDR_W
) (
    input  logic              en_i,
    input  logic [ADDR_W-1:0] rs1e_i,
    input  logic [ADDR_W-1:0] rs2e_i,
    input  logic [ADDR_W-1:0] rdm_i,
    input  logic [ADDR_W-1:0] rdw_i,
    input  logic              regwritem_i,
    input  logic              regwritew_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o
);

    logic m_ok;
    logic w_ok;

    assign m_ok = regwritem_i & (rdm_i != '0);
    assign w_ok = regwritew_i & (rdw_i != '0);

    always_comb begin
        fwd_a_o = FWD_RF;
        fwd_b_o = FWD_RF;
        if (en_i) begin
            if (m_ok && rdm_i == rs1e_i)      fwd_a_o = FWD_MEM;
            else if (w_ok && rdw_i == rs1e_i) fwd_a_o = FWD_WB;
            if (m_ok && rdm_i == rs2e_i)      fwd_b_o = FWD_MEM;
            else if (w_ok && rdw_i == rs2e_i) fwd_b_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, forwarding, regfile clear.
// Define HAZARD_PERF_CNT_EN to add stall_cnt / flush_cnt outputs.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = HZ_ADDR_W,
    parameter int SKIP_INIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Rs1D,
    input  logic [ADDR_W-1:0] Rs2D,
    input  logic [ADDR_W-1:0] Rs1E,
    input  logic [ADDR_W-1:0] Rs2E,
    input  logic [ADDR_W-1:0] RdE,
    input  logic [ADDR_W-1:0] RdM,
    input  logic [ADDR_W-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE,
    input  logic              PCSrcE,
    input  logic              dmem_req_M,
    input  logic              dmem_ready,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic              init_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
    localparam hz_state_e RST_STATE = (SKIP_INIT != 0) ? ST_RUN : ST_INIT;

    hz_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              fwd_en;
    logic              lw_stall;
    logic              mem_stall;

    assign lw_stall  = ResultSrcE & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));
    assign mem_stall = dmem_req_M & ~dmem_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        init_we   = 1'b0;
        init_addr = '0;
        init_busy = 1'b0;
        fwd_en    = 1'b1;
        if (!rst) begin
            {StallF, StallD, StallE, StallM} = 4'hF;
            FlushE    = 1'b1;
            init_busy = 1'b1;
            fwd_en    = 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    {StallF, StallD, StallE, StallM} = 4'hF;
                    FlushE    = 1'b1;
                    init_busy = 1'b1;
                    init_we   = 1'b1;
                    init_addr = cnt_q;
                    fwd_en    = 1'b0;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_REG) state_d = ST_RUN;
                end
                ST_RUN: begin
                    // A frozen pipeline cannot act on branch or load-use.
                    if (mem_stall) begin
                        {StallF, StallD, StallE, StallM} = 4'hF;
                        FlushW  = 1'b1;
                        state_d = ST_MEM_WAIT;
                    end else if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (lw_stall) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    {StallF, StallD, StallE, StallM} = 4'hF;
                    FlushW = 1'b1;
                    if (dmem_ready) state_d = ST_RUN;
                end
                default: begin
                    {StallF, StallD, StallE, StallM} = 4'hF;
                    FlushE    = 1'b1;
                    init_busy = 1'b1;
                    fwd_en    = 1'b0;
                    state_d   = ST_INIT;
                    cnt_d     = '0;
                end
            endcase
        end
    end

    forward_unit #(.ADDR_W(ADDR_W)) u_fwd (
        .en_i        (fwd_en),
        .rs1e_i      (Rs1E),
        .rs2e_i      (Rs2E),
        .rdm_i       (RdM),
        .rdw_i       (RdW),
        .regwritem_i (RegWriteM),
        .regwritew_i (RegWriteW),
        .fwd_a_o     (ForwardAE),
        .fwd_b_o     (ForwardBE)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((state_q == ST_RUN || state_q == ST_MEM_WAIT) && StallF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (state_q == ST_RUN && (FlushD || FlushE))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
